// File: rtl/systolic_result_drain_if.sv
// Bundle between the systolic array top level, the result drain and the downstream consumer.
// The slave modport is the drain itself; the master modport is whoever feeds it and consumes the stream.
interface systolic_result_drain_if #(
  parameter int N = 4
);
  localparam int IDX_W = $clog2(N);

  logic [N-1:0][N-1:0][31:0] i_c;
  logic                      i_validResult;
  logic                      i_ready;
  logic                      i_clearDropped;
  logic                      o_valid;
  logic [31:0]               o_data;
  logic [IDX_W-1:0]          o_row;
  logic [IDX_W-1:0]          o_col;
  logic                      o_last;
  logic                      o_busy;
  logic                      o_dropped;

  modport slave (
    input  i_c, i_validResult, i_ready, i_clearDropped,
    output o_valid, o_data, o_row, o_col, o_last, o_busy, o_dropped
  );

  modport master (
    output i_c, i_validResult, i_ready, i_clearDropped,
    input  o_valid, o_data, o_row, o_col, o_last, o_busy, o_dropped
  );
endinterface

// File: rtl/systolic_result_drain.sv
// Captures a whole N x N result matrix in one cycle and streams it out row-major over valid/ready,
// flagging results that arrive while a previous matrix is still draining.
module systolic_result_drain #(
  parameter int N = 4
) (
  input  logic                    i_clk,
  input  logic                    i_arst,
  systolic_result_drain_if.slave  bus
);
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          row_q, row_d;
  logic [IDX_W-1:0]          col_q, col_d;
  logic                      dropped_q, dropped_d;
  logic [N-1:0][N-1:0][31:0] buffer_q;

  logic lastBeat;
  logic xfer;
  logic capture;
  logic drop;

  assign lastBeat = (state_q == DRAIN) && (row_q == LAST_IDX) && (col_q == LAST_IDX);
  assign xfer     = (state_q == DRAIN) && bus.i_ready;

  // A strobe landing on the final transfer is a back-to-back recapture, not a drop.
  assign capture  = bus.i_validResult && ((state_q == IDLE) || (xfer && lastBeat));
  assign drop     = bus.i_validResult && (state_q == DRAIN) && !(xfer && lastBeat);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    if (capture) begin
      state_d = DRAIN;
      row_d   = '0;
      col_d   = '0;
    end else if (xfer) begin
      if (lastBeat) begin
        state_d = IDLE;
        row_d   = '0;
        col_d   = '0;
      end else if (col_q == LAST_IDX) begin
        col_d = '0;
        row_d = row_q + IDX_W'(1);
      end else begin
        col_d = col_q + IDX_W'(1);
      end
    end
  end

  // Set has priority over clear so a drop is never lost to a coincident clear.
  always_comb begin
    dropped_d = dropped_q;
    if (drop) begin
      dropped_d = 1'b1;
    end else if (bus.i_clearDropped) begin
      dropped_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      dropped_q <= 1'b0;
      buffer_q  <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      dropped_q <= dropped_d;
      if (capture) begin
        buffer_q <= bus.i_c;
      end
    end
  end

  assign bus.o_valid   = (state_q == DRAIN);
  assign bus.o_busy    = (state_q == DRAIN);
  assign bus.o_last    = lastBeat;
  assign bus.o_row     = row_q;
  assign bus.o_col     = col_q;
  assign bus.o_data    = buffer_q[row_q][col_q];
  assign bus.o_dropped = dropped_q;
endmodule

// File: tb/tb_systolic_result_drain.sv
// Scoreboard bench for systolic_result_drain: directed matrices push expected beats into a queue,
// and a negedge monitor pops and compares every accepted beat and checks stall stability.
module tb_systolic_result_drain;
  localparam int N = 4;

  typedef logic [N-1:0][N-1:0][31:0] mat_t;
  typedef struct {
    logic [31:0] data;
    logic [1:0]  row;
    logic [1:0]  col;
    logic        last;
  } beat_t;

  logic  i_clk;
  logic  i_arst;
  int    checks;
  int    failures;
  beat_t qExp[$];

  systolic_result_drain_if #(.N(N)) bus ();

  systolic_result_drain #(.N(N)) dut (
    .i_clk  (i_clk),
    .i_arst (i_arst),
    .bus    (bus.slave)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic pushBeats(input mat_t m, input int count);
    beat_t b;
    for (int k = 0; k < count; k++) begin
      b.data = m[k / N][k % N];
      b.row  = 2'(k / N);
      b.col  = 2'(k % N);
      b.last = (k == N * N - 1);
      qExp.push_back(b);
    end
  endtask

  // One-cycle result strobe carrying matrix m.
  task automatic applyStimulus(input mat_t m);
    bus.i_c           = m;
    bus.i_validResult = 1'b1;
    tick();
    bus.i_validResult = 1'b0;
  endtask

  // Monitor: every beat accepted on the next edge must match the head of the scoreboard.
  initial begin
    beat_t       b;
    logic        prevStall;
    logic [31:0] prevData;
    logic [4:0]  prevTag;
    prevStall = 1'b0;
    prevData  = '0;
    prevTag   = '0;
    forever begin
      @(negedge i_clk);
      if (!i_arst && bus.o_valid) begin
        if (prevStall) begin
          checkOutput("stallData", bus.o_data, prevData);
          checkOutput("stallTag", 32'({bus.o_row, bus.o_col, bus.o_last}), 32'(prevTag));
        end
        if (bus.i_ready) begin
          if (qExp.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpectedBeat: got data 0x%0h at (%0d,%0d), expected no beat",
                     bus.o_data, bus.o_row, bus.o_col);
          end else begin
            b = qExp.pop_front();
            checkOutput("beatData", bus.o_data, b.data);
            checkOutput("beatTag", 32'({bus.o_row, bus.o_col, bus.o_last}), 32'({b.row, b.col, b.last}));
          end
        end
      end
      prevStall = !i_arst && bus.o_valid && !bus.i_ready;
      prevData  = bus.o_data;
      prevTag   = {bus.o_row, bus.o_col, bus.o_last};
    end
  end

  initial begin
    mat_t mBase;
    mat_t mNext;
    mat_t mOnes;
    int   busyCount;

    checks   = 0;
    failures = 0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        mBase[r][c] = 32'(16 * r + c);
        mNext[r][c] = 32'(100 + r + c);
        mOnes[r][c] = 32'hFFFF_FFFF;
      end
    end

    i_arst             = 1'b1;
    bus.i_c            = '0;
    bus.i_validResult  = 1'b0;
    bus.i_ready        = 1'b1;
    bus.i_clearDropped = 1'b0;
    tick();
    tick();
    checkOutput("resetValid", 32'(bus.o_valid), 0);
    checkOutput("resetBusy", 32'(bus.o_busy), 0);
    checkOutput("resetLast", 32'(bus.o_last), 0);
    checkOutput("resetDropped", 32'(bus.o_dropped), 0);
    checkOutput("resetData", bus.o_data, 0);
    checkOutput("resetIdx", 32'({bus.o_row, bus.o_col}), 0);
    i_arst = 1'b0;
    tick();

    // Full-rate drain: 16 beats, busy for exactly 16 cycles.
    pushBeats(mBase, N * N);
    applyStimulus(mBase);
    busyCount = 0;
    repeat (40) begin
      @(negedge i_clk);
      if (bus.o_busy) busyCount++;
    end
    checkOutput("fullRateBusyCycles", 32'(busyCount), 16);
    checkOutput("fullRateValidAfter", 32'(bus.o_valid), 0);
    checkOutput("fullRateQueueEmpty", 32'(qExp.size()), 0);
    tick();

    // Alternating ready: same sequence, complete after 31 busy cycles.
    pushBeats(mBase, N * N);
    applyStimulus(mBase);
    busyCount = 0;
    repeat (45) begin
      @(negedge i_clk);
      if (bus.o_busy) busyCount++;
      tick();
      bus.i_ready = ~bus.i_ready;
    end
    bus.i_ready = 1'b1;
    checkOutput("toggleBusyCycles", 32'(busyCount), 31);
    checkOutput("toggleQueueEmpty", 32'(qExp.size()), 0);
    tick();

    // Input matrix changes during drain must not leak through.
    pushBeats(mBase, N * N);
    applyStimulus(mBase);
    bus.i_c = mOnes;
    repeat (25) tick();
    checkOutput("holdQueueEmpty", 32'(qExp.size()), 0);

    // Drop at beat 5, then coincident set/clear, then clear alone.
    pushBeats(mBase, N * N);
    applyStimulus(mBase);
    repeat (4) tick();
    bus.i_c           = mOnes;
    bus.i_validResult = 1'b1;
    tick();
    bus.i_validResult = 1'b0;
    checkOutput("dropSet", 32'(bus.o_dropped), 1);
    repeat (2) tick();
    bus.i_validResult  = 1'b1;
    bus.i_clearDropped = 1'b1;
    tick();
    bus.i_validResult  = 1'b0;
    bus.i_clearDropped = 1'b0;
    checkOutput("dropSetBeatsClear", 32'(bus.o_dropped), 1);
    repeat (12) tick();
    checkOutput("dropDrainDone", 32'(bus.o_busy), 0);
    checkOutput("dropSticky", 32'(bus.o_dropped), 1);
    checkOutput("dropQueueEmpty", 32'(qExp.size()), 0);
    bus.i_clearDropped = 1'b1;
    tick();
    bus.i_clearDropped = 1'b0;
    checkOutput("dropCleared", 32'(bus.o_dropped), 0);

    // Back-to-back: strobe on the last transfer recaptures with no bubble.
    pushBeats(mBase, N * N);
    pushBeats(mNext, N * N);
    applyStimulus(mBase);
    repeat (15) tick();
    checkOutput("b2bLastPresented", 32'(bus.o_last), 1);
    bus.i_c           = mNext;
    bus.i_validResult = 1'b1;
    tick();
    bus.i_validResult = 1'b0;
    checkOutput("b2bValid", 32'(bus.o_valid), 1);
    checkOutput("b2bData", bus.o_data, 100);
    checkOutput("b2bIdx", 32'({bus.o_row, bus.o_col}), 0);
    checkOutput("b2bNoDrop", 32'(bus.o_dropped), 0);
    repeat (20) tick();
    checkOutput("b2bQueueEmpty", 32'(qExp.size()), 0);
    checkOutput("b2bIdleAfter", 32'(bus.o_valid), 0);

    // Asynchronous reset mid-drain at beat 7, then a clean restart.
    pushBeats(mBase, 6);
    applyStimulus(mBase);
    repeat (2) tick();
    bus.i_c           = mOnes;
    bus.i_validResult = 1'b1;
    tick();
    bus.i_validResult = 1'b0;
    checkOutput("preResetDropped", 32'(bus.o_dropped), 1);
    repeat (3) tick();
    i_arst = 1'b1;
    #1;
    checkOutput("asyncResetValid", 32'(bus.o_valid), 0);
    checkOutput("asyncResetBusy", 32'(bus.o_busy), 0);
    checkOutput("asyncResetLast", 32'(bus.o_last), 0);
    checkOutput("asyncResetDropped", 32'(bus.o_dropped), 0);
    checkOutput("asyncResetIdx", 32'({bus.o_row, bus.o_col}), 0);
    checkOutput("asyncResetQueueEmpty", 32'(qExp.size()), 0);
    tick();
    i_arst = 1'b0;
    tick();
    pushBeats(mNext, N * N);
    applyStimulus(mNext);
    checkOutput("restartData", bus.o_data, 100);
    repeat (20) tick();
    checkOutput("restartQueueEmpty", 32'(qExp.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
